result_dumper: RTL

- Sits downstream of RISCVCPU and consumes its end-of-program outputs: `done`, `clock_count`, `instr_cnt`, and the byte-wide data memory.
- On the rising edge of `done` it snapshots both counters and reads the M×N2 result matrix out of data memory.
- Each result is assembled as a big-endian 32-bit word (byte at the lowest address is the MSB).
- Words are streamed out over a valid/ready interface. This replaces hierarchical peeking at D_Memory by benches and on-board readout logic.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/result_dumper_byte_word_assembler.sv | 52 +++++
 rtl/result_dumper.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISCVCPU matrix program and its result dumper.
// Holds matrix-dimension defaults, the result-area base, dump states and header layout.
package riscv_pkg;
  localparam int M_DEF  = 3;
  localparam int N_DEF  = 4;
  localparam int N2_DEF = 3;

  // Result matrix sits after matrix1 (M x N) and matrix2 (N x N2), 4 bytes per element.
  function automatic int res_base(input int m, input int n, input int n2);
    return m * n * 4 + n * n2 * 4;
  endfunction

  typedef enum logic [2:0] {
    IDLE, HDR, FETCH, PRESENT, CKS, DONE
  } dump_state_e;

  localparam int HDR_CC_LSB = 16;
  localparam int HDR_IC_LSB = 0;

  function automatic logic [31:0] make_header(input logic [15:0] cc, input logic [15:0] ic);
    logic [31:0] h;
    h = '0;
    h[HDR_CC_LSB +: 16] = cc;
    h[HDR_IC_LSB +: 16] = ic;
    return h;
  endfunction
endpackage

// File: rtl/result_dumper_byte_word_assembler.sv
// byte_word_assembler: while run_i is high, issues 4 sequential byte reads (1-cycle latency)
// and shifts them into a big-endian word; word_rdy_o pulses as the last byte is captured.
module byte_word_assembler
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [31:0]       word_o,
  output logic              word_rdy_o
);
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_q;
  logic              last_q;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_now;

  assign mem_rd_o   = run_i & ~cnt_q[2];
  assign addr_now   = base_addr_i + ADDR_W'(cnt_q[1:0]);
  // The address bus holds its last issued value whenever no read is in flight.
  assign mem_addr_o = mem_rd_o ? addr_now : addr_q;
  assign word_o     = word_q;
  assign word_rdy_o = last_q;

  always_comb begin
    cnt_d = 3'd0;
    if (run_i) cnt_d = cnt_q[2] ? cnt_q : cnt_q + 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 3'd0;
      rd_q   <= 1'b0;
      last_q <= 1'b0;
      word_q <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= mem_rd_o;
      last_q <= mem_rd_o & (cnt_q[1:0] == 2'd3);
      if (mem_rd_o) addr_q <= addr_now;
      if (rd_q) word_q <= {word_q[23:0], mem_rdata_i};
    end
  end
endmodule

// File: rtl/result_dumper.sv
// result_dumper: on a rising edge of done_i, streams {clock_count, instr_cnt} then the
// M x N2 result matrix from data memory. RESULT_DUMP_CHECKSUM_EN appends a sum word.
//   state   | meaning
//   IDLE    | waiting for a fresh done_i rising edge
//   HDR     | presenting the counter snapshot
//   FETCH   | reading 4 bytes of result word w
//   PRESENT | presenting result word w
//   CKS     | presenting the running sum (checksum build only)
//   DONE    | dump complete, waiting for done_i to drop
module result_dumper
  import riscv_pkg::*;
#(
  parameter int M      = M_DEF,
  parameter int N      = N_DEF,
  parameter int N2     = N2_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              done_i,
  input  logic [15:0]       clock_count_i,
  input  logic [15:0]       instr_cnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              finished
);
  localparam int RES_BASE = res_base(M, N, N2);
  localparam int NWORDS   = M * N2;
  localparam int WW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(NWORDS - 1);

  dump_state_e       state_q, state_d;
  logic              done_q;
  logic [31:0]       hdr_q, hdr_d;
  logic [WW-1:0]     w_q, w_d;
  logic [31:0]       asm_word;
  logic              asm_rdy;
  logic              asm_run;
  logic              trig;
  logic [ADDR_W-1:0] word_base;
`ifdef RESULT_DUMP_CHECKSUM_EN
  logic [31:0]       cks_q, cks_d;
`endif

  assign trig      = done_i & ~done_q;
  assign word_base = ADDR_W'(RES_BASE) + ADDR_W'({w_q, 2'b00});

  byte_word_assembler #(.ADDR_W(ADDR_W)) u_asm (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .run_i       (asm_run),
    .base_addr_i (word_base),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_rdata_i (mem_rdata_i),
    .word_o      (asm_word),
    .word_rdy_o  (asm_rdy)
  );

  // Tracks done_i through reset so a level already high at reset release never triggers.
  always_ff @(posedge CLOCK_50) done_q <= done_i;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      w_q     <= '0;
`ifdef RESULT_DUMP_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      w_q     <= w_d;
`ifdef RESULT_DUMP_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    w_d       = w_q;
    asm_run   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
`ifdef RESULT_DUMP_CHECKSUM_EN
    cks_d     = cks_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig) begin
          hdr_d   = make_header(clock_count_i, instr_cnt_i);
`ifdef RESULT_DUMP_CHECKSUM_EN
          cks_d   = '0;
`endif
          state_d = HDR;
        end
      end
      HDR: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = hdr_q;
        if (out_ready) begin
          w_d     = '0;
`ifdef RESULT_DUMP_CHECKSUM_EN
          cks_d   = cks_q + hdr_q;
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        asm_run = 1'b1;
        if (asm_rdy) state_d = PRESENT;
      end
      PRESENT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = asm_word;
`ifndef RESULT_DUMP_CHECKSUM_EN
        out_last  = (w_q == W_LAST);
`endif
        if (out_ready) begin
`ifdef RESULT_DUMP_CHECKSUM_EN
          cks_d = cks_q + asm_word;
`endif
          if (w_q != W_LAST) begin
            w_d     = w_q + WW'(1);
            state_d = FETCH;
          end else begin
`ifdef RESULT_DUMP_CHECKSUM_EN
            state_d = CKS;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef RESULT_DUMP_CHECKSUM_EN
      CKS: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = cks_q;
        out_last  = 1'b1;
        if (out_ready) state_d = DONE;
      end
`endif
      DONE: begin
        finished = 1'b1;
        if (!done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
